// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: register offsets, reset constants and small helpers shared
// by the core-local interruptor.
package clint_timer_pkg;

  // Byte offsets relative to the block's base address.
  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  // Compare value after reset: the largest value, so no interrupt until software programs it.
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Which architectural register a bus address selects.
  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  // Word-aligned decode; the two byte-offset bits are ignored.
  function automatic reg_sel_e decode_offset(input logic [15:0] addr);
    logic [15:0] word;
    word = {addr[15:2], 2'b00};
    case (word)
      CLINT_MSIP:        return REG_MSIP;
      CLINT_MTIMECMP_LO: return REG_CMP_LO;
      CLINT_MTIMECMP_HI: return REG_CMP_HI;
      CLINT_MTIME_LO:    return REG_TIME_LO;
      CLINT_MTIME_HI:    return REG_TIME_HI;
      default:           return REG_NONE;
    endcase
  endfunction

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides the clock into mtime ticks. The count runs
// 0..PRESCALE-1 and tick is high while the count sits at PRESCALE-1.
module clint_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Prescale counter: wraps on the tick, restarts on reset or clear.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor. Holds mtime, mtimecmp and msip behind a
// single-cycle bus responder and drives the timer/software interrupt lines.
// Optional feature macro CLINT_MTIME_LATCH_EN: a read of the low mtime word
// snapshots the high word so the following high-word read is atomic.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int          PRESCALE  = 1,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  // Base address is decoded by the surrounding interconnect, not here.
  logic unused_base;
  assign unused_base = ^BASE_ADDR;

  reg_sel_e    sel;
  logic        time_wr;
  logic        tick;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_next;
  logic        msip_next;
  logic [31:0] rd_value;

`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] mtime_shadow;
`endif

  assign sel     = decode_offset(bus_addr);
  assign time_wr = bus_wen && ((sel == REG_TIME_LO) || (sel == REG_TIME_HI));

  // A software write to mtime on a tick edge restarts the prescale period.
  clint_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (time_wr && tick),
    .tick  (tick)
  );

  // Read multiplexer over the current (pre-write) register values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_value = '0;
    case (sel)
      REG_MSIP:    rd_value = {31'd0, msip};
      REG_CMP_LO:  rd_value = mtimecmp[31:0];
      REG_CMP_HI:  rd_value = mtimecmp[63:32];
      REG_TIME_LO: rd_value = mtime[31:0];
`ifdef CLINT_MTIME_LATCH_EN
      REG_TIME_HI: rd_value = mtime_shadow;
`else
      REG_TIME_HI: rd_value = mtime[63:32];
`endif
      default:     rd_value = '0;
    endcase
  end

  // Register next-state: byte-merged bus writes; an mtime write swallows that edge's tick.
  always_comb begin
    mtime_next    = mtime;
    mtimecmp_next = mtimecmp;
    msip_next     = msip;
    if (bus_wen) begin
      case (sel)
        REG_MSIP:    if (bus_wstrb[0]) msip_next = bus_wdata[0];
        REG_CMP_LO:  mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0], bus_wdata, bus_wstrb);
        REG_CMP_HI:  mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], bus_wdata, bus_wstrb);
        REG_TIME_LO: mtime_next[31:0]     = merge_bytes(mtime[31:0], bus_wdata, bus_wstrb);
        REG_TIME_HI: mtime_next[63:32]    = merge_bytes(mtime[63:32], bus_wdata, bus_wstrb);
        default:     ;
      endcase
    end
    if (!time_wr && tick) begin
      mtime_next = mtime + 64'd1;
    end
  end

  // Architectural timer and software-interrupt registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RESET;
      msip     <= 1'b0;
    end else begin
      mtime    <= mtime_next;
      mtimecmp <= mtimecmp_next;
      msip     <= msip_next;
    end
  end

  // Bus response: one-cycle ready for every request; read data holds until the next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= bus_wen || bus_ren;
      if (bus_ren) begin
        bus_rdata <= rd_value;
      end
    end
  end

`ifdef CLINT_MTIME_LATCH_EN
  // Snapshot of the high mtime word taken alongside every low-word read.
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_shadow <= '0;
    end else if (bus_ren && (sel == REG_TIME_LO)) begin
      mtime_shadow <= mtime[63:32];
    end
  end
`endif

  // Level-sensitive timer interrupt from the current register outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_interrupt <= 1'b0;
    end else begin
      timer_interrupt <= (mtime >= mtimecmp);
    end
  end

  assign software_interrupt = msip;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: two instances (PRESCALE=1 and PRESCALE=4) share one bus.
// A transaction-level model predicts every output each cycle; directed
// sequences pin the model with hand-computed literals, then random traffic
// (including mid-transaction resets) runs against the model.
`timescale 1ns/1ps
module tb_clint_timer;

  localparam int P0 = 1;
  localparam int P1 = 4;

  logic        clock;
  logic        reset;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_wen;
  logic        bus_ren;

  logic [31:0] rdata_o [2];
  logic        ready_o [2];
  logic        tint_o  [2];
  logic        sint_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  clint_timer #(.PRESCALE(P0), .BASE_ADDR(16'h0000)) dut0 (
    .clock              (clock),
    .reset              (reset),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_wstrb          (bus_wstrb),
    .bus_wen            (bus_wen),
    .bus_ren            (bus_ren),
    .bus_rdata          (rdata_o[0]),
    .bus_ready          (ready_o[0]),
    .timer_interrupt    (tint_o[0]),
    .software_interrupt (sint_o[0])
  );

  clint_timer #(.PRESCALE(P1), .BASE_ADDR(16'h0000)) dut1 (
    .clock              (clock),
    .reset              (reset),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_wstrb          (bus_wstrb),
    .bus_wen            (bus_wen),
    .bus_ren            (bus_ren),
    .bus_rdata          (rdata_o[1]),
    .bus_ready          (ready_o[1]),
    .timer_interrupt    (tint_o[1]),
    .software_interrupt (sint_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [63:0] m_time   [2];
  bit [63:0] m_cmp    [2];
  bit        m_msip   [2];
  int        m_cnt    [2];
  bit [31:0] m_rdata  [2];
  bit [31:0] m_shadow [2];
  bit        m_ready  [2];
  bit        m_tint   [2];
  bit        m_valid = 1'b0;

  function automatic bit [31:0] merge32(bit [31:0] old, bit [31:0] d, bit [3:0] s);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic void model_step(int k, int p);
    bit [15:0] off;
    bit        tick;
    bit        twr;
    if (reset) begin
      m_time[k] = 64'd0;  m_cmp[k] = '1;     m_msip[k] = 1'b0; m_cnt[k] = 0;
      m_rdata[k] = 32'd0; m_shadow[k] = 32'd0; m_ready[k] = 1'b0; m_tint[k] = 1'b0;
      return;
    end
    off = {bus_addr[15:2], 2'b00};
    m_tint[k]  = (m_time[k] >= m_cmp[k]);
    m_ready[k] = bus_wen || bus_ren;
    if (bus_ren) begin
      case (off)
        16'h0000: m_rdata[k] = {31'd0, m_msip[k]};
        16'h4000: m_rdata[k] = m_cmp[k][31:0];
        16'h4004: m_rdata[k] = m_cmp[k][63:32];
        16'hBFF8: m_rdata[k] = m_time[k][31:0];
`ifdef CLINT_MTIME_LATCH_EN
        16'hBFFC: m_rdata[k] = m_shadow[k];
`else
        16'hBFFC: m_rdata[k] = m_time[k][63:32];
`endif
        default:  m_rdata[k] = 32'd0;
      endcase
      if (off == 16'hBFF8) m_shadow[k] = m_time[k][63:32];
    end
    tick = (m_cnt[k] == p - 1);
    m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
    twr = bus_wen && (off == 16'hBFF8 || off == 16'hBFFC);
    if (bus_wen) begin
      case (off)
        16'h0000: if (bus_wstrb[0]) m_msip[k] = bus_wdata[0];
        16'h4000: m_cmp[k][31:0]   = merge32(m_cmp[k][31:0], bus_wdata, bus_wstrb);
        16'h4004: m_cmp[k][63:32]  = merge32(m_cmp[k][63:32], bus_wdata, bus_wstrb);
        16'hBFF8: m_time[k][31:0]  = merge32(m_time[k][31:0], bus_wdata, bus_wstrb);
        16'hBFFC: m_time[k][63:32] = merge32(m_time[k][63:32], bus_wdata, bus_wstrb);
        default:  ;
      endcase
    end
    if (!twr && tick) m_time[k] = m_time[k] + 64'd1;
  endfunction

  // Model advances on every active edge from the inputs sampled there.
  always @(posedge clock) begin
    model_step(0, P0);
    model_step(1, P1);
    if (reset) m_valid = 1'b1;
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clock) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rdata[%0d]", k), 64'(rdata_o[k]), 64'(m_rdata[k]));
        check($sformatf("ready[%0d]", k), 64'(ready_o[k]), 64'(m_ready[k]));
        check($sformatf("tint[%0d]", k),  64'(tint_o[k]),  64'(m_tint[k]));
        check($sformatf("sint[%0d]", k),  64'(sint_o[k]),  64'(m_msip[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input bit w, input bit r, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    reset = rst; bus_wen = w; bus_ren = r; bus_addr = a; bus_wdata = d; bus_wstrb = s;
    @(posedge clock); #1;
    bus_wen = 1'b0; bus_ren = 1'b0; reset = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'd0, 4'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc(1'b0, 1'b1, 1'b0, a, d, s);
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 32'd0, 4'h0);
  endtask

  initial begin
    bit found;
    bit        w, r;
    logic [15:0] a;
    logic [31:0] d;
    reset = 1'b1; bus_wen = 1'b0; bus_ren = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset rdata", 64'(rdata_o[0]), 64'd0);
    check("reset tint",  64'(tint_o[0]),  64'd0);
    reset = 1'b0;

    // Free-running count after reset.
    repeat (10) idle();
    rd(16'hBFF8);
    check("mtime after 10 (P=1)", 64'(rdata_o[0]), 64'd10);
    check("mtime after 10 (P=4)", 64'(rdata_o[1]), 64'd2);
    check("ready on read", 64'(ready_o[0]), 64'd1);
    check("tint idle", 64'(tint_o[0]), 64'd0);
    idle();
    check("ready one cycle", 64'(ready_o[0]), 64'd0);
    rd(16'hBFF8);
    check("mtime after 12 (P=1)", 64'(rdata_o[0]), 64'd12);
    check("mtime after 12 (P=4)", 64'(rdata_o[1]), 64'd3);

    // Timer interrupt rise and fall.
    wr(16'h4004, 32'd0, 4'hF);
    wr(16'h4000, 32'd20, 4'hF);
    wr(16'hBFF8, 32'd15, 4'hF);
    repeat (5) idle();
    check("tint before compare", 64'(tint_o[0]), 64'd0);
    idle();
    check("tint rises", 64'(tint_o[0]), 64'd1);
    wr(16'h4000, 32'd1000, 4'hF);
    check("tint still high", 64'(tint_o[0]), 64'd1);
    idle();
    check("tint falls", 64'(tint_o[0]), 64'd0);

    // Software interrupt and byte strobes.
    wr(16'h0000, 32'd1, 4'h1);
    check("msip set", 64'(sint_o[0]), 64'd1);
    wr(16'h0000, 32'd0, 4'h0);
    check("msip no strobe", 64'(sint_o[0]), 64'd1);
    wr(16'h0000, 32'd0, 4'h1);
    check("msip clear", 64'(sint_o[0]), 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 16'h0000, 32'd1, 4'h1);
    check("rd+wr old value", 64'(rdata_o[0]), 64'd0);
    check("rd+wr written", 64'(sint_o[0]), 64'd1);
    rd(16'h0000);
    check("msip readback", 64'(rdata_o[0]), 64'd1);
    wr(16'h0000, 32'd0, 4'hF);

    // 64-bit wrap with mtimecmp at its maximum.
    wr(16'h4000, 32'hFFFF_FFFF, 4'hF);
    wr(16'h4004, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    idle();
    check("tint at max", 64'(tint_o[0]), 64'd1);
    rd(16'hBFF8);
    check("tint after wrap", 64'(tint_o[0]), 64'd0);
    check("wrap lo", 64'(rdata_o[0]), 64'd0);
    rd(16'hBFFC);
    check("wrap hi", 64'(rdata_o[0]), 64'd0);

    // Write coinciding with a PRESCALE=4 tick.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_cnt[1] == P1 - 1) found = 1'b1;
      else idle();
    end
    check("tick alignment found", 64'(found), 64'd1);
    wr(16'hBFF8, 32'h100, 4'hF);
    rd(16'hBFF8);
    check("written held (P=4)", 64'(rdata_o[1]), 64'h100);
    check("written (P=1)", 64'(rdata_o[0]), 64'h100);
    idle();
    idle();
    rd(16'hBFF8);
    check("no tick yet (P=4)", 64'(rdata_o[1]), 64'h100);
    check("counting (P=1)", 64'(rdata_o[0]), 64'h103);
    rd(16'hBFF8);
    check("restarted tick (P=4)", 64'(rdata_o[1]), 64'h101);

    // Atomic 64-bit read across a low-word carry.
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    wr(16'hBFFC, 32'h0000_0001, 4'hF);
    rd(16'hBFF8);
    check("latch lo", 64'(rdata_o[0]), 64'hFFFF_FFFE);
    idle();
    rd(16'hBFFC);
`ifdef CLINT_MTIME_LATCH_EN
    check("latch hi shadow", 64'(rdata_o[0]), 64'd1);
`else
    check("latch hi live", 64'(rdata_o[0]), 64'd2);
`endif

    // Unmapped offset.
    rd(16'h1234);
    check("unmapped rdata", 64'(rdata_o[0]), 64'd0);
    check("unmapped ready", 64'(ready_o[0]), 64'd1);

    // Random traffic, occasionally with reset in the middle of a request.
    for (int n = 0; n < 3000; n++) begin
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       a = 16'h0000;
        1:       a = 16'h4000;
        2:       a = 16'h4004;
        3:       a = 16'hBFF8;
        4:       a = 16'hBFFC;
        default: a = 16'($urandom);
      endcase
      a[1:0] = 2'($urandom);
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 64));
      cyc(($urandom_range(0, 99) == 0), w, r, a, d, 4'($urandom));
    end
    idle();
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
